// File: rtl/shader_program_encoder.sv
// Shader program encoder: packs field-level instructions into 32-bit words
// and streams them into program memory, optionally NOP-padding the tail.
module shader_program_encoder #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter bit PAD_NOPS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [3:0]        in_mask,
  input  logic [2:0]        in_dest,
  input  logic [2:0]        in_srcA,
  input  logic [2:0]        in_srcB,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PAD
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              done_q;
  logic [ADDR_W:0]   count_q;
  logic              ovf_q;

  logic              hs;
  logic              at_end;
  logic [31:0]       enc_d;

  assign hs     = (state_q == LOAD) && in_valid;
  assign at_end = (ptr_q == LAST);

  // A zero lane mask disables every lane, so it collapses to the canonical NOP.
  always_comb begin
    enc_d = {in_op, in_mask, in_dest, in_srcA, in_srcB, 17'b0};
    if (in_mask == 4'b0000) enc_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q   <= start_addr;
            count_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (hs) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ptr_q;
            wr_data_q <= enc_d;
            count_q   <= count_q + 1'b1;
            if (at_end && !in_last) ovf_q <= 1'b1;
            if (in_last || at_end) begin
              if (PAD_NOPS && !at_end) begin
                ptr_q   <= ptr_q + 1'b1;
                state_q <= PAD;
              end else begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        PAD: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= ptr_q;
          wr_data_q <= '0;
          if (at_end) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
